// File: rtl/sdram_word_bridge.sv
// sdram_word_bridge: sequences one 32-bit PicoRV32 native-bus access into
// up to two 16-bit SDRAM controller commands (read, write or read-modify-write
// per halfword), reassembles read data and returns a single cpu_ready pulse.
// A watchdog aborts any access whose controller stops responding.
module sdram_word_bridge #(
   parameter int unsigned HADDR_WIDTH    = 22,
   parameter int unsigned TIMEOUT_CYCLES = 1023
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   cpu_valid,
   input  logic [31:0]            cpu_addr,
   input  logic [31:0]            cpu_wdata,
   input  logic [3:0]             cpu_wstrb,
   output logic                   cpu_ready,
   output logic [31:0]            cpu_rdata,
   output logic [HADDR_WIDTH-1:0] sd_addr,
   output logic [15:0]            sd_wr_data,
   output logic                   sd_wr_enable,
   output logic                   sd_rd_enable,
   input  logic [15:0]            sd_rd_data,
   input  logic                   sd_rd_ready,
   input  logic                   sd_busy,
   output logic                   timeout_err
);

   localparam int unsigned WD_BITS =
      ($clog2(TIMEOUT_CYCLES + 1) < 10) ? 10 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WD_BITS-1:0] WD_LAST     = WD_BITS'(TIMEOUT_CYCLES - 1);
   localparam logic [31:0]        ABORT_RDATA = 32'hDEAD_BEEF;

   typedef enum logic [2:0] {
      IDLE,
      RD_ISSUE,
      RD_WAIT,
      WR_ISSUE,
      WR_WAIT,
      DONE
   } state_t;

   typedef enum logic [1:0] {
      PLAN_SKIP,
      PLAN_READ,
      PLAN_WRITE,
      PLAN_RMW
   } plan_t;

   // What one halfword needs, given the access type and its two byte strobes.
   function automatic plan_t half_plan(input logic is_read, input logic [1:0] strb);
      plan_t p;
      if (is_read) begin
         p = PLAN_READ;
      end else begin
         case (strb)
            2'b11:   p = PLAN_WRITE;
            2'b00:   p = PLAN_SKIP;
            default: p = PLAN_RMW;
         endcase
      end
      return p;
   endfunction

   state_t                 state_q, state_d;
   logic [HADDR_WIDTH-2:0] word_q, word_d;
   logic [31:0]            wdata_q, wdata_d;
   logic [3:0]             wstrb_q, wstrb_d;
   logic                   rd_acc_q, rd_acc_d;
   logic                   half_q, half_d;
   logic [15:0]            rbuf_q, rbuf_d;
   logic [WD_BITS-1:0]     wd_cnt_q, wd_cnt_d;
   logic                   busy_seen_q, busy_seen_d;

   logic                   cpu_ready_d;
   logic [31:0]            cpu_rdata_d;
   logic [HADDR_WIDTH-1:0] sd_addr_d;
   logic [15:0]            sd_wr_data_d;
   logic                   sd_wr_enable_d;
   logic                   sd_rd_enable_d;
   logic                   timeout_err_d;

   logic                   in_txn;
   logic                   half_done;
   logic                   go_start;
   plan_t                  st_plan;
   logic                   st_half;
   logic [31:0]            st_wdata;
   logic [1:0]             cur_strb;
   logic [15:0]            cur_wd;
   plan_t                  cur_plan;
   plan_t                  hi_plan;
   logic [15:0]            merged;

   logic                   unused_addr_bits;
   assign unused_addr_bits = ^{cpu_addr[31:HADDR_WIDTH+1], cpu_addr[1:0]};

   // Next-state, datapath and registered-output values for the sequencer.
   always_comb begin
      state_d        = state_q;
      word_d         = word_q;
      wdata_d        = wdata_q;
      wstrb_d        = wstrb_q;
      rd_acc_d       = rd_acc_q;
      half_d         = half_q;
      rbuf_d         = rbuf_q;
      wd_cnt_d       = wd_cnt_q;
      busy_seen_d    = busy_seen_q;
      cpu_ready_d    = 1'b0;
      cpu_rdata_d    = cpu_rdata;
      sd_addr_d      = sd_addr;
      sd_wr_data_d   = sd_wr_data;
      sd_wr_enable_d = 1'b0;
      sd_rd_enable_d = 1'b0;
      timeout_err_d  = timeout_err;
      half_done      = 1'b0;
      go_start       = 1'b0;
      st_plan        = PLAN_SKIP;
      st_half        = 1'b0;
      st_wdata       = wdata_q;

      in_txn   = (state_q == RD_ISSUE) || (state_q == RD_WAIT) ||
                 (state_q == WR_ISSUE) || (state_q == WR_WAIT);
      cur_strb = half_q ? wstrb_q[3:2] : wstrb_q[1:0];
      cur_wd   = half_q ? wdata_q[31:16] : wdata_q[15:0];
      cur_plan = half_plan(rd_acc_q, cur_strb);
      hi_plan  = half_plan(rd_acc_q, wstrb_q[3:2]);
      merged   = {cur_strb[1] ? cur_wd[15:8] : sd_rd_data[15:8],
                  cur_strb[0] ? cur_wd[7:0]  : sd_rd_data[7:0]};

      if (in_txn) begin
         wd_cnt_d = wd_cnt_q + WD_BITS'(1);
      end

      if (in_txn && (wd_cnt_q == WD_LAST)) begin
         state_d       = DONE;
         cpu_ready_d   = 1'b1;
         cpu_rdata_d   = rd_acc_q ? ABORT_RDATA : '0;
         timeout_err_d = 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (cpu_valid) begin
                  word_d   = cpu_addr[HADDR_WIDTH:2];
                  wdata_d  = cpu_wdata;
                  wstrb_d  = cpu_wstrb;
                  rd_acc_d = (cpu_wstrb == 4'b0000);
                  go_start = 1'b1;
                  st_wdata = cpu_wdata;
                  if (half_plan(rd_acc_d, cpu_wstrb[1:0]) != PLAN_SKIP) begin
                     st_half = 1'b0;
                     st_plan = half_plan(rd_acc_d, cpu_wstrb[1:0]);
                  end else begin
                     st_half = 1'b1;
                     st_plan = half_plan(rd_acc_d, cpu_wstrb[3:2]);
                  end
               end
            end
            RD_ISSUE: begin
               if (!sd_busy) begin
                  sd_rd_enable_d = 1'b1;
                  state_d        = RD_WAIT;
               end
            end
            RD_WAIT: begin
               if (sd_rd_ready) begin
                  if (!half_q) begin
                     rbuf_d = sd_rd_data;
                  end
                  if (cur_plan == PLAN_RMW) begin
                     sd_wr_data_d = merged;
                     state_d      = WR_ISSUE;
                  end else begin
                     half_done = 1'b1;
                  end
               end
            end
            WR_ISSUE: begin
               if (!sd_busy) begin
                  sd_wr_enable_d = 1'b1;
                  busy_seen_d    = 1'b0;
                  state_d        = WR_WAIT;
               end
            end
            WR_WAIT: begin
               if (sd_busy) begin
                  busy_seen_d = 1'b1;
               end else if (busy_seen_q) begin
                  half_done = 1'b1;
               end
            end
            DONE: begin
               state_d = IDLE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase

         // Finishing a half either starts the upper half or completes the access;
         // a read's upper half arrives on sd_rd_data in this same cycle.
         if (half_done) begin
            if (!half_q && (hi_plan != PLAN_SKIP)) begin
               go_start = 1'b1;
               st_half  = 1'b1;
               st_plan  = hi_plan;
            end else begin
               state_d     = DONE;
               cpu_ready_d = 1'b1;
               cpu_rdata_d = rd_acc_q ? {sd_rd_data, rbuf_q} : '0;
            end
         end
      end

      if (go_start) begin
         half_d    = st_half;
         sd_addr_d = {word_d, st_half};
         if (st_plan == PLAN_WRITE) begin
            state_d      = WR_ISSUE;
            sd_wr_data_d = st_half ? st_wdata[31:16] : st_wdata[15:0];
         end else begin
            state_d = RD_ISSUE;
         end
      end

      if (((state_d == RD_ISSUE) || (state_d == WR_ISSUE)) &&
          !((state_q == RD_ISSUE) || (state_q == WR_ISSUE))) begin
         wd_cnt_d = '0;
      end
   end

   // State, latched access and registered outputs; reset abandons any command.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         word_q       <= '0;
         wdata_q      <= '0;
         wstrb_q      <= '0;
         rd_acc_q     <= 1'b0;
         half_q       <= 1'b0;
         rbuf_q       <= '0;
         wd_cnt_q     <= '0;
         busy_seen_q  <= 1'b0;
         cpu_ready    <= 1'b0;
         cpu_rdata    <= '0;
         sd_addr      <= '0;
         sd_wr_data   <= '0;
         sd_wr_enable <= 1'b0;
         sd_rd_enable <= 1'b0;
         timeout_err  <= 1'b0;
      end else begin
         state_q      <= state_d;
         word_q       <= word_d;
         wdata_q      <= wdata_d;
         wstrb_q      <= wstrb_d;
         rd_acc_q     <= rd_acc_d;
         half_q       <= half_d;
         rbuf_q       <= rbuf_d;
         wd_cnt_q     <= wd_cnt_d;
         busy_seen_q  <= busy_seen_d;
         cpu_ready    <= cpu_ready_d;
         cpu_rdata    <= cpu_rdata_d;
         sd_addr      <= sd_addr_d;
         sd_wr_data   <= sd_wr_data_d;
         sd_wr_enable <= sd_wr_enable_d;
         sd_rd_enable <= sd_rd_enable_d;
         timeout_err  <= timeout_err_d;
      end
   end

endmodule

// File: tb/tb_sdram_word_bridge.sv
// tb_sdram_word_bridge: directed tests for sdram_word_bridge with a behavioural
// SDRAM controller, a per-access command/read-data predictor and one checker.
module tb_sdram_word_bridge;

   localparam int unsigned HW     = 22;
   localparam int unsigned TMO    = 1023;
   localparam int          RD_LAT = 3;

   typedef struct packed {
      logic          wr;
      logic [HW-1:0] addr;
      logic [15:0]   data;
   } op_t;

   logic          clk;
   logic          rst_n;
   logic          cpu_valid;
   logic [31:0]   cpu_addr;
   logic [31:0]   cpu_wdata;
   logic [3:0]    cpu_wstrb;
   logic          cpu_ready;
   logic [31:0]   cpu_rdata;
   logic [HW-1:0] sd_addr;
   logic [15:0]   sd_wr_data;
   logic          sd_wr_enable;
   logic          sd_rd_enable;
   logic [15:0]   sd_rd_data;
   logic          sd_rd_ready;
   logic          sd_busy;
   logic          timeout_err;

   int n_checks = 0;
   int n_fail   = 0;

   op_t         exp_ops[$];
   logic [31:0] exp_rd[$];
   logic [15:0] ref_mem [int unsigned];
   logic [15:0] ctl_mem [int unsigned];

   int          cyc           = 0;
   int          ready_cnt     = 0;
   int          en_cnt        = 0;
   int          first_en_cyc  = 0;
   int          busy_fall_cyc = 0;
   logic [31:0] last_rdata    = '0;
   bit          force_busy    = 0;
   bit          hang_rd       = 0;

   sdram_word_bridge #(
      .HADDR_WIDTH   (HW),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cpu_valid   (cpu_valid),
      .cpu_addr    (cpu_addr),
      .cpu_wdata   (cpu_wdata),
      .cpu_wstrb   (cpu_wstrb),
      .cpu_ready   (cpu_ready),
      .cpu_rdata   (cpu_rdata),
      .sd_addr     (sd_addr),
      .sd_wr_data  (sd_wr_data),
      .sd_wr_enable(sd_wr_enable),
      .sd_rd_enable(sd_rd_enable),
      .sd_rd_data  (sd_rd_data),
      .sd_rd_ready (sd_rd_ready),
      .sd_busy     (sd_busy),
      .timeout_err (timeout_err)
   );

   // 100 MHz clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop if something hangs outside the bounded waits.
   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation still running, required completion");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] ref_rd(input int unsigned a);
      return ref_mem.exists(a) ? ref_mem[a] : 16'h0000;
   endfunction

   function automatic logic [15:0] ctl_rd(input int unsigned a);
      return ctl_mem.exists(a) ? ctl_mem[a] : 16'h0000;
   endfunction

   task automatic preload(input int unsigned a, input logic [15:0] d);
      ref_mem[a] = d;
      ctl_mem[a] = d;
   endtask

   // Expected controller commands and cpu_rdata for one access, from the
   // halfword/strobe rules applied to the reference memory.
   task automatic predict(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st);
      logic [31:0] rd;
      int unsigned base;
      int unsigned ha;
      logic [1:0]  s;
      logic [15:0] wh;
      logic [15:0] m;
      rd   = '0;
      base = (a >> 2) & 32'h001F_FFFF;
      for (int h = 0; h < 2; h++) begin
         s  = st[2*h +: 2];
         wh = wd[16*h +: 16];
         ha = base * 2 + h;
         if (st == 4'b0000) begin
            exp_ops.push_back('{wr: 1'b0, addr: HW'(ha), data: 16'h0});
            rd[16*h +: 16] = ref_rd(ha);
         end else if (s == 2'b11) begin
            exp_ops.push_back('{wr: 1'b1, addr: HW'(ha), data: wh});
            ref_mem[ha] = wh;
         end else if (s != 2'b00) begin
            m = ref_rd(ha);
            exp_ops.push_back('{wr: 1'b0, addr: HW'(ha), data: 16'h0});
            if (s[0]) m[7:0]  = wh[7:0];
            if (s[1]) m[15:8] = wh[15:8];
            exp_ops.push_back('{wr: 1'b1, addr: HW'(ha), data: m});
            ref_mem[ha] = m;
         end
      end
      exp_rd.push_back((st == 4'b0000) ? rd : 32'h0);
   endtask

   // Checker plus controller model, once per cycle on the falling edge.
   initial begin
      op_t  e;
      bit   prev_en;
      bit   en;
      bit   busy_dut;
      bit   new_busy;
      int   rd_cnt;
      int   wr_cnt;
      logic [HW-1:0] rd_addr;
      prev_en     = 0;
      rd_cnt      = 0;
      wr_cnt      = 0;
      rd_addr     = '0;
      sd_busy     = 1'b0;
      sd_rd_ready = 1'b0;
      sd_rd_data  = 16'h0;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) begin
            prev_en     = 0;
            rd_cnt      = 0;
            wr_cnt      = 0;
            sd_rd_ready = 1'b0;
            sd_busy     = force_busy;
         end else begin
            busy_dut = sd_busy;
            en       = sd_rd_enable | sd_wr_enable;
            if (en) begin
               en_cnt++;
               if (first_en_cyc < 0) first_en_cyc = cyc;
               chk("enable_while_busy", 32'(busy_dut), 32'h0);
               chk("enable_back_to_back", 32'(prev_en), 32'h0);
               chk("both_enables", 32'(sd_rd_enable & sd_wr_enable), 32'h0);
               if (exp_ops.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL unexpected_cmd: got wr=%0b addr %h, required no command",
                           sd_wr_enable, sd_addr);
               end else begin
                  e = exp_ops.pop_front();
                  chk("cmd_is_write", 32'(sd_wr_enable), 32'(e.wr));
                  chk("cmd_addr", 32'(sd_addr), 32'(e.addr));
                  if (e.wr) chk("cmd_wdata", 32'(sd_wr_data), 32'(e.data));
               end
            end
            prev_en = en;
            if (cpu_ready) begin
               ready_cnt++;
               last_rdata = cpu_rdata;
               if (exp_rd.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL unexpected_ready: got cpu_ready, required none");
               end else begin
                  chk("cpu_rdata", cpu_rdata, exp_rd.pop_front());
               end
            end
            // Controller: fixed read latency, two busy cycles per write.
            sd_rd_ready = 1'b0;
            if (rd_cnt > 0) begin
               rd_cnt--;
               if (rd_cnt == 0 && !hang_rd) begin
                  sd_rd_ready = 1'b1;
                  sd_rd_data  = ctl_rd(int'(rd_addr));
               end
            end
            if (wr_cnt > 0) wr_cnt--;
            if (sd_rd_enable) begin
               rd_cnt  = RD_LAT;
               rd_addr = sd_addr;
            end
            if (sd_wr_enable) begin
               ctl_mem[int'(sd_addr)] = sd_wr_data;
               wr_cnt = 2;
            end
            new_busy = force_busy || (rd_cnt > 0) || (wr_cnt > 0);
            if (sd_busy && !new_busy && busy_fall_cyc < 0) busy_fall_cyc = cyc;
            sd_busy = new_busy;
         end
      end
   end

   // One CPU access; inputs are scrambled after acceptance to prove latching.
   task automatic access(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st,
                         input int budget, input int hold, output int lat);
      int r0;
      int e0;
      bit got;
      got = 0;
      lat = 0;
      @(negedge clk); #1;
      cpu_valid = 1'b1;
      cpu_addr  = a;
      cpu_wdata = wd;
      cpu_wstrb = st;
      r0 = ready_cnt;
      e0 = en_cnt;
      for (int k = 1; k <= budget && !got; k++) begin
         @(negedge clk); #1;
         if (k == 1) begin
            cpu_addr  = ~a;
            cpu_wdata = ~wd;
            cpu_wstrb = ~st;
         end
         if (hold > 0 && k == hold) begin
            chk("busy_hold_no_enable", 32'(en_cnt - e0), 32'h0);
            busy_fall_cyc = -1;
            first_en_cyc  = -1;
            force_busy    = 0;
         end
         if (ready_cnt != r0) begin
            got = 1;
            lat = k;
         end
      end
      cpu_valid = 1'b0;
      if (!got) begin
         n_checks++;
         n_fail++;
         $display("FAIL ready_wait: got no cpu_ready in %0d cycles, required one", budget);
      end
      repeat (3) @(negedge clk);
      #1;
      chk("ready_pulse_count", 32'(ready_cnt - r0), 32'h1);
      chk("cmds_outstanding", 32'(exp_ops.size()), 32'h0);
   endtask

   initial begin
      int lat;
      int e0;
      bit seen;
      rst_n     = 1'b0;
      cpu_valid = 1'b0;
      cpu_addr  = '0;
      cpu_wdata = '0;
      cpu_wstrb = '0;

      repeat (3) @(negedge clk);
      #1;
      chk("rst_cpu_ready", 32'(cpu_ready), 32'h0);
      chk("rst_cpu_rdata", cpu_rdata, 32'h0);
      chk("rst_sd_addr", 32'(sd_addr), 32'h0);
      chk("rst_sd_wr_data", 32'(sd_wr_data), 32'h0);
      chk("rst_sd_wr_enable", 32'(sd_wr_enable), 32'h0);
      chk("rst_sd_rd_enable", 32'(sd_rd_enable), 32'h0);
      chk("rst_timeout_err", 32'(timeout_err), 32'h0);
      rst_n = 1'b1;

      // 1: full read
      preload(8, 16'h1234);
      preload(9, 16'hABCD);
      predict(32'h0400_0010, 32'h0, 4'b0000);
      access(32'h0400_0010, 32'h0, 4'b0000, 200, 0, lat);
      chk("t1_rdata", last_rdata, 32'hABCD_1234);
      chk("t1_timeout_err", 32'(timeout_err), 32'h0);

      // 2: full write
      predict(32'h0400_0020, 32'hCAFE_F00D, 4'b1111);
      access(32'h0400_0020, 32'hCAFE_F00D, 4'b1111, 200, 0, lat);
      chk("t2_rdata", last_rdata, 32'h0);
      chk("t2_mem_10", 32'(ctl_rd(32'h10)), 32'h0000_F00D);
      chk("t2_mem_11", 32'(ctl_rd(32'h11)), 32'h0000_CAFE);

      // 3: single-byte RMW in the upper half only
      preload(32'h10, 16'h7777);
      preload(32'h11, 16'h1122);
      predict(32'h0400_0020, 32'h00AA_0000, 4'b0100);
      access(32'h0400_0020, 32'h00AA_0000, 4'b0100, 200, 0, lat);
      chk("t3_mem_11", 32'(ctl_rd(32'h11)), 32'h0000_11AA);
      chk("t3_mem_10_untouched", 32'(ctl_rd(32'h10)), 32'h0000_7777);

      // 4: RMW in both halves
      preload(32'h10, 16'hAAAA);
      preload(32'h11, 16'hBBBB);
      predict(32'h0400_0020, 32'h5500_0066, 4'b1001);
      access(32'h0400_0020, 32'h5500_0066, 4'b1001, 200, 0, lat);
      chk("t4_mem_10", 32'(ctl_rd(32'h10)), 32'h0000_AA66);
      chk("t4_mem_11", 32'(ctl_rd(32'h11)), 32'h0000_55BB);

      // 5: controller busy for 50 cycles before the first command
      force_busy = 1;
      repeat (2) @(negedge clk);
      predict(32'h0400_0010, 32'h0, 4'b0000);
      access(32'h0400_0010, 32'h0, 4'b0000, 300, 50, lat);
      chk("t5_rdata", last_rdata, 32'hABCD_1234);
      chk("t5_enable_after_busy_fall", 32'(first_en_cyc - busy_fall_cyc), 32'h1);

      // 6a: read data never returns
      hang_rd = 1;
      exp_ops.push_back('{wr: 1'b0, addr: HW'(8), data: 16'h0});
      exp_rd.push_back(32'hDEAD_BEEF);
      access(32'h0400_0010, 32'h0, 4'b0000, TMO + 100, 0, lat);
      hang_rd = 0;
      chk("t6_abort_rdata", last_rdata, 32'hDEAD_BEEF);
      chk("t6_timeout_err", 32'(timeout_err), 32'h1);
      chk("t6_abort_latency_window", 32'((lat >= int'(TMO)) && (lat <= int'(TMO) + 2)), 32'h1);

      // 6b: reset while the first write waits on a stuck-busy controller
      exp_ops.push_back('{wr: 1'b1, addr: HW'(32'h10), data: 16'h5678});
      @(negedge clk); #1;
      cpu_valid = 1'b1;
      cpu_addr  = 32'h0400_0020;
      cpu_wdata = 32'h1234_5678;
      cpu_wstrb = 4'b1111;
      e0   = en_cnt;
      seen = 0;
      for (int k = 1; k <= 50 && !seen; k++) begin
         @(negedge clk); #1;
         if (k == 1) cpu_valid = 1'b0;
         if (en_cnt != e0) seen = 1;
      end
      if (!seen) begin
         n_checks++;
         n_fail++;
         $display("FAIL t6_write_issue: got no command in 50 cycles, required a write");
      end
      force_busy = 1;
      repeat (4) @(negedge clk);
      #1;
      chk("t6_timeout_err_sticky", 32'(timeout_err), 32'h1);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_cpu_ready", 32'(cpu_ready), 32'h0);
      chk("t6_rst_cpu_rdata", cpu_rdata, 32'h0);
      chk("t6_rst_sd_addr", 32'(sd_addr), 32'h0);
      chk("t6_rst_sd_wr_data", 32'(sd_wr_data), 32'h0);
      chk("t6_rst_sd_wr_enable", 32'(sd_wr_enable), 32'h0);
      chk("t6_rst_sd_rd_enable", 32'(sd_rd_enable), 32'h0);
      chk("t6_rst_timeout_err", 32'(timeout_err), 32'h0);
      repeat (2) @(negedge clk);
      #1;
      force_busy = 0;
      exp_ops.delete();
      exp_rd.delete();
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // 6c: the full read works again after reset
      preload(8, 16'h1234);
      preload(9, 16'hABCD);
      predict(32'h0400_0010, 32'h0, 4'b0000);
      access(32'h0400_0010, 32'h0, 4'b0000, 200, 0, lat);
      chk("t6_recovery_rdata", last_rdata, 32'hABCD_1234);
      chk("t6_recovery_timeout_err", 32'(timeout_err), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sdram_word_bridge.md
Name: sdram_word_bridge

Overview:
Sequencer between the PicoRV32 32-bit native memory bus and the 16-bit single-command SDRAM controller. It splits each 32-bit access into one or two halfword commands, and uses read-modify-write for partial-halfword byte strobes. It reassembles 32-bit read data and returns a single ready pulse, with a watchdog so a hung controller cannot stall the CPU forever. It sits in the SoC top between the SDRAM address decode (0x0400_0000 window) and the controller host port.

Parameters:
HADDR_WIDTH, 22, halfword address width of controller host port; cpu_addr[HADDR_WIDTH:2] is the word index.
TIMEOUT_CYCLES, 1023, max cycles spent in any ISSUE/WAIT state of one access before abort (10-bit counter minimum).

Ports:
clk  input  1  system clock (PLL c0), all logic on rising edge
rst_n  input  1  asynchronous active-low reset
cpu_valid  input  1  access request, already qualified by SDRAM address decode
cpu_addr  input  32  byte address; bits [1:0] ignored
cpu_wdata  input  32  write data, little-endian
cpu_wstrb  input  4  byte strobes; 0000 = read
cpu_ready  output  1  one-cycle completion pulse
cpu_rdata  output  32  read data, valid while cpu_ready high
sd_addr  output  HADDR_WIDTH  halfword address to controller
sd_wr_data  output  16  halfword write data
sd_wr_enable  output  1  write command strobe
sd_rd_enable  output  1  read command strobe
sd_rd_data  input  16  controller read data
sd_rd_ready  input  1  read data valid pulse
sd_busy  input  1  controller busy
timeout_err  output  1  sticky watchdog flag

Behaviour:
- Reset (async, rst_n low): state IDLE; cpu_ready, cpu_rdata, sd_addr, sd_wr_data, sd_wr_enable, sd_rd_enable and timeout_err = 0. The timeout counter and half index are cleared. A controller command in flight is abandoned and not tracked.
- All outputs are registered.
- States: IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, WR_WAIT, DONE.
- Per-half plan, latched in IDLE when cpu_valid=1. For half h (0 = bits 15:0, 1 = bits 31:16), s = wstrb[2h+1:2h]:
  - read access: READ for both halves;
  - s=11: WRITE;
  - s=01 or 10: RMW;
  - s=00 on a write: SKIP.
- Halves are processed h=0 then h=1; SKIP halves issue nothing. sd_addr = {cpu_addr[HADDR_WIDTH:2], h}.
- READ/RMW enter RD_ISSUE. WRITE enters WR_ISSUE. When all halves are done, go to DONE.
- RD_ISSUE/WR_ISSUE: when sd_busy=0, assert the enable for exactly one cycle with sd_addr and sd_wr_data stable, then go to WAIT. Enables are never high while sd_busy=1 and never high two consecutive cycles.
- RD_WAIT:
  - on sd_rd_ready, capture sd_rd_data into the half buffer;
  - READ: next half;
  - RMW: go to WR_ISSUE with merged data: each byte from cpu_wdata if its strobe is set, otherwise from the captured data.
- WR_WAIT: completes when sd_busy has been sampled 1 and then 0 (busy-seen flag); then next half.
- DONE: cpu_ready=1 for one cycle. For reads, cpu_rdata = {half1, half0}; for writes, cpu_rdata = 0. Then go to IDLE.
- Handshake: the master drops cpu_valid the cycle after cpu_ready. IDLE samples cpu_valid only in IDLE. Inputs are latched at acceptance, so later changes are ignored.
- Write with wstrb=0 after decode never occurs; it is treated as a read.
- Watchdog: the counter resets at each ISSUE entry and increments in ISSUE/WAIT. On reaching TIMEOUT_CYCLES, the access aborts to DONE:
  - reads return 32'hDEAD_BEEF; writes return 0;
  - the remaining halves are dropped;
  - timeout_err is set and stays set until reset.
- Minimum latency, full read with idle controller and read latency L (enable to rd_ready): cpu_ready at 2·(L+1)+2 cycles after acceptance. No pipelining; one access outstanding.

Test Plan:
1. Full read of cpu_addr 0x0400_0010; model holds 0x1234 at halfword 0x8 and 0xABCD at 0x9 -> rd pulses at sd_addr 0x8 then 0x9, no writes, single cpu_ready with cpu_rdata 0xABCD1234.
2. Full write, wstrb 1111, wdata 0xCAFEF00D, addr 0x0400_0020 -> writes 0xF00D at 0x10 then 0xCAFE at 0x11, no reads, one ready, cpu_rdata 0.
3. RMW: wstrb 0100, wdata 0x00AA0000, addr 0x0400_0020, model 0x11 = 0x1122 -> rd 0x11, then wr 0x11 data 0x11AA; halfword 0x10 untouched.
4. Split RMW: wstrb 1001, wdata 0x55000066, model 0x10=0xAAAA, 0x11=0xBBBB -> rd 0x10, wr 0xAA66, rd 0x11, wr 0x55BB.
5. Busy hold: sd_busy held 1 for 50 cycles before the first issue -> no enable during those cycles; enable exactly one cycle after busy falls; access completes normally.
6. Timeout, then reset recovery:
   - model never asserts rd_ready -> after TIMEOUT_CYCLES, cpu_ready pulses with 0xDEADBEEF and timeout_err=1;
   - pulse rst_n low mid-WR_WAIT -> all outputs 0 immediately and timeout_err clears;
   - case 1 then passes.
